fb_write_scheduler: RTL and testbench
=====================================

Name: fb_write_scheduler

Overview:
- Owns the single write port of the 64x64, 1-bit VGA framebuffer RAM (4096 words: pixel, wraddress, enable).
- Shares that port between two pixel requesters: req0 is the coprocessor result writer and req1 is the overlay/drawing writer.
- Contains a built-in clear sequencer that fills every framebuffer address with one value and then reports completion.
- Sits between the image coprocessor and the framebuffer RAM, ahead of the VGA read side.

Parameters:
- ADDR_WIDTH, 12, framebuffer address width.
- DEPTH, 4096, number of framebuffer words. Must equal 2**ADDR_WIDTH.

Ports:
- clock_50MHz  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clear_start  input  1  single-cycle request to clear the framebuffer.
- clear_value  input  1  fill value; sampled in the cycle clear_start is accepted.
- clear_busy  output  1  high while clear writes are being issued.
- clear_done  output  1  one-cycle pulse after the last clear write.
- req0_valid  input  1  requester 0 has a pixel write pending.
- req0_addr  input  ADDR_WIDTH  requester 0 target address.
- req0_pixel  input  1  requester 0 pixel value.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid  input  1  requester 1 has a pixel write pending.
- req1_addr  input  ADDR_WIDTH  requester 1 target address.
- req1_pixel  input  1  requester 1 pixel value.
- req1_ready  output  1  requester 1 write accepted this cycle.
- pixel  output  1  framebuffer write data (registered).
- wraddress  output  ADDR_WIDTH  framebuffer write address (registered).
- enable  output  1  framebuffer write enable (registered).

Behaviour:
- Reset, applied on a clock edge with reset=1:
  - State goes to SERVE.
  - pixel=0, wraddress=0, enable=0.
  - clear_busy=0, clear_done=0.
  - Clear counter=0; last_grant=1, so req0 wins the first contention.
  - Reset has priority over every other input, and also aborts a clear already in progress.
- State SERVE, grant rules:
  - reqN_ready is combinational from state, the valids and last_grant.
  - Only one valid high: that requester gets ready=1.
  - Both valid high: the requester not equal to last_grant gets ready=1 (round-robin).
  - Neither valid high: both readies are 0.
  - At most one ready is ever high.
- State SERVE, write timing:
  - A handshake (valid & ready) in cycle T produces enable=1, wraddress=addr and pixel=pixel in cycle T+1. Latency is 1 cycle.
  - last_grant updates to the granted requester.
  - Back-to-back handshakes give one write per cycle.
- State SERVE, idle cycle (no handshake): enable=0 in the next cycle; wraddress and pixel hold their values.
- clear_start in SERVE:
  - clear_start has priority over both requesters; in that cycle both readies are forced to 0.
  - clear_value is latched.
  - State moves to CLEAR.
- State CLEAR:
  - Both readies are 0 and pending valids are stalled (requesters keep valid high).
  - With clear_start accepted in cycle T, a write appears in every cycle T+1 .. T+DEPTH: enable=1, pixel=latched clear_value, wraddress=0,1,...,DEPTH-1 in order.
  - clear_busy=1 during T+1 .. T+DEPTH.
  - In cycle T+DEPTH+1: enable=0, clear_busy=0, clear_done=1 for exactly that one cycle, and state is SERVE. Grants may occur in that same cycle.
  - clear_start asserted during CLEAR is ignored: no restart and no queued second clear. clear_value changes during CLEAR are also ignored.
- Counter width: the counter is ADDR_WIDTH+1 bits so the last address is detected without wrap-around ambiguity. It never wraps to 0 while issuing writes.
- last_grant is unchanged by a clear.

Test Plan:
- Reset then idle → enable=0, wraddress=0, pixel=0, clear_busy=0, both readies 0; req0_valid=1 in the next cycle gives req0_ready=1 immediately.
- Single requester write: req1_valid=1, addr=0x07F, pixel=1 in cycle T → req1_ready=1 in T; enable=1, wraddress=0x07F, pixel=1 in T+1; enable=0 in T+2 once valid is dropped.
- Contention: both valid held for 4 cycles with distinct addresses → grants alternate req0, req1, req0, req1; four consecutive enable=1 cycles carry the matching addresses and pixels.
- Full clear: clear_start=1, clear_value=1 in cycle T → exactly 4096 enable cycles with wraddress 0..4095 ascending and pixel=1; clear_busy high over the same span; clear_done high only in T+4097; no ready during T..T+4096.
- Collisions: clear_start and req0_valid asserted in the same cycle → req0_ready=0 and the clear runs. A second clear_start at cycle T+100 → still exactly 4096 writes. req0 is granted in T+4097.
- Reset mid-clear: reset asserted at T+2000 → in the next cycle enable=0, clear_busy=0, no clear_done pulse, state SERVE; a new clear started afterwards begins again at wraddress=0.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: round-robin arbitration between two pixel
// requesters plus a sequencer that fills every address with one value.
module fb_write_scheduler #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clock_50MHz,
    input  logic                  reset,
    input  logic                  clear_start,
    input  logic                  clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_pixel,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_pixel,
    output logic                  req1_ready,
    output logic                  pixel,
    output logic [ADDR_WIDTH-1:0] wraddress,
    output logic                  enable
);

    typedef enum logic {SERVE, CLEAR} state_t;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] CNT_END = CW'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  clear_val_q, clear_val_d;
    logic                  last_grant_q, last_grant_d;
    logic                  pixel_q, pixel_d;
    logic [ADDR_WIDTH-1:0] wraddress_q, wraddress_d;
    logic                  enable_q, enable_d;
    logic                  clear_busy_q, clear_busy_d;
    logic                  clear_done_q, clear_done_d;

    always_ff @(posedge clock_50MHz) begin
        if (reset) begin
            state_q      <= SERVE;
            cnt_q        <= '0;
            clear_val_q  <= 1'b0;
            last_grant_q <= 1'b1;
            pixel_q      <= 1'b0;
            wraddress_q  <= '0;
            enable_q     <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clear_val_q  <= clear_val_d;
            last_grant_q <= last_grant_d;
            pixel_q      <= pixel_d;
            wraddress_q  <= wraddress_d;
            enable_q     <= enable_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Address 0 is issued directly on acceptance, so the counter already
    // holds the next address (1) when CLEAR is entered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_val_d  = clear_val_q;
        last_grant_d = last_grant_q;
        pixel_d      = pixel_q;
        wraddress_d  = wraddress_q;
        enable_d     = 1'b0;
        clear_busy_d = clear_busy_q;
        clear_done_d = 1'b0;
        case (state_q)
            SERVE: begin
                if (clear_start) begin
                    state_d      = CLEAR;
                    clear_val_d  = clear_value;
                    enable_d     = 1'b1;
                    wraddress_d  = '0;
                    pixel_d      = clear_value;
                    cnt_d        = CW'(1);
                    clear_busy_d = 1'b1;
                end else if (req0_ready) begin
                    enable_d     = 1'b1;
                    wraddress_d  = req0_addr;
                    pixel_d      = req0_pixel;
                    last_grant_d = 1'b0;
                end else if (req1_ready) begin
                    enable_d     = 1'b1;
                    wraddress_d  = req1_addr;
                    pixel_d      = req1_pixel;
                    last_grant_d = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == CNT_END) begin
                    state_d      = SERVE;
                    cnt_d        = '0;
                    clear_busy_d = 1'b0;
                    clear_done_d = 1'b1;
                end else begin
                    enable_d     = 1'b1;
                    wraddress_d  = cnt_q[ADDR_WIDTH-1:0];
                    pixel_d      = clear_val_q;
                    cnt_d        = cnt_q + CW'(1);
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == SERVE && !clear_start) begin
            req0_ready = req0_valid && (!req1_valid || last_grant_q);
            req1_ready = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign pixel      = pixel_q;
    assign wraddress  = wraddress_q;
    assign enable     = enable_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: arbitration, write latency, full
// clear sequencing, clear/request collisions and reset during a clear.
module tb_fb_write_scheduler;

    localparam int AW = 12;
    localparam int DP = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_start, clear_value;
    logic          clear_busy, clear_done;
    logic          req0_valid, req0_pixel, req0_ready;
    logic [AW-1:0] req0_addr;
    logic          req1_valid, req1_pixel, req1_ready;
    logic [AW-1:0] req1_addr;
    logic          pixel, enable;
    logic [AW-1:0] wraddress;

    int n_checks = 0;
    int n_fail   = 0;

    fb_write_scheduler #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clock_50MHz(clk),
        .reset(reset),
        .clear_start(clear_start),
        .clear_value(clear_value),
        .clear_busy(clear_busy),
        .clear_done(clear_done),
        .req0_valid(req0_valid),
        .req0_addr(req0_addr),
        .req0_pixel(req0_pixel),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr(req1_addr),
        .req1_pixel(req1_pixel),
        .req1_ready(req1_ready),
        .pixel(pixel),
        .wraddress(wraddress),
        .enable(enable)
    );

    always #10 clk = ~clk;

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_start = 1'b0; clear_value = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_pixel = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_pixel = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({enable, pixel, clear_busy, clear_done, req0_ready, req1_ready} !== 6'b0 || wraddress !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: en=%b pix=%b busy=%b done=%b r0=%b r1=%b addr=%h, required all 0",
                     enable, pixel, clear_busy, clear_done, req0_ready, req1_ready, wraddress);
        end
        step();
        req0_valid = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: r0=%b r1=%b, required r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_single();
        step();
        req1_valid = 1'b1; req1_addr = 12'h07F; req1_pixel = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: r0=%b r1=%b, required r0=0 r1=1", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        n_checks++;
        if (enable !== 1'b1 || wraddress !== 12'h07F || pixel !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: en=%b addr=%h pix=%b, required en=1 addr=07f pix=1", enable, wraddress, pixel);
        end
        step();
        n_checks++;
        if (enable !== 1'b0 || wraddress !== 12'h07F || pixel !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: en=%b addr=%h pix=%b, required en=0 addr=07f pix=1", enable, wraddress, pixel);
        end
    endtask

    task automatic test_contention();
        logic          exp_g;
        logic [AW-1:0] exp_addr;
        logic          exp_pix;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_addr = 12'h100 + AW'(i); req0_pixel = 1'b0;
            req1_addr = 12'h200 + AW'(i); req1_pixel = 1'b1;
            #1;
            exp_g    = (i % 2) != 0;
            exp_addr = exp_g ? req1_addr : req0_addr;
            exp_pix  = exp_g;
            n_checks++;
            if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: r0=%b r1=%b, required r0=%b r1=%b",
                         i, req0_ready, req1_ready, !exp_g, exp_g);
            end
            step();
            if (i == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            n_checks++;
            if (enable !== 1'b1 || wraddress !== exp_addr || pixel !== exp_pix) begin
                n_fail++;
                $display("FAIL contention_write[%0d]: en=%b addr=%h pix=%b, required en=1 addr=%h pix=%b",
                         i, enable, wraddress, pixel, exp_addr, exp_pix);
            end
        end
        step();
    endtask

    task automatic test_full_clear();
        req1_valid = 1'b1; req1_addr = 12'h333; req1_pixel = 1'b0;
        clear_start = 1'b1; clear_value = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_accept_ready: r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
        end
        step();
        clear_start = 1'b0; clear_value = 1'b0;
        for (int k = 0; k < DP; k++) begin
            n_checks++;
            if (enable !== 1'b1 || wraddress !== AW'(k) || pixel !== 1'b1 || clear_busy !== 1'b1 ||
                clear_done !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_write[%0d]: en=%b addr=%h pix=%b busy=%b done=%b r1=%b, required en=1 addr=%h pix=1 busy=1 done=0 r1=0",
                         k, enable, wraddress, pixel, clear_busy, clear_done, req1_ready, AW'(k));
            end
            step();
        end
        n_checks++;
        if (enable !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b1 || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_done: en=%b busy=%b done=%b r1=%b, required en=0 busy=0 done=1 r1=1",
                     enable, clear_busy, clear_done, req1_ready);
        end
        req1_valid = 1'b0;
        step();
        n_checks++;
        if (clear_done !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done_pulse: done=%b en=%b, required done=0 en=0", clear_done, enable);
        end
    endtask

    task automatic test_collision();
        req0_valid = 1'b1; req0_addr = 12'h055; req0_pixel = 1'b1;
        clear_start = 1'b1; clear_value = 1'b0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_ready: r0=%b, required 0", req0_ready);
        end
        step();
        clear_start = 1'b0; clear_value = 1'b1;
        for (int k = 0; k < DP; k++) begin
            clear_start = (k == 99);
            #1;
            n_checks++;
            if (enable !== 1'b1 || wraddress !== AW'(k) || pixel !== 1'b0 || req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL collision_write[%0d]: en=%b addr=%h pix=%b r0=%b, required en=1 addr=%h pix=0 r0=0",
                         k, enable, wraddress, pixel, req0_ready, AW'(k));
            end
            step();
        end
        clear_start = 1'b0;
        #1;
        n_checks++;
        if (enable !== 1'b0 || clear_done !== 1'b1 || req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_end: en=%b done=%b r0=%b, required en=0 done=1 r0=1", enable, clear_done, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if (enable !== 1'b1 || wraddress !== 12'h055 || pixel !== 1'b1 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_grant_write: en=%b addr=%h pix=%b busy=%b, required en=1 addr=055 pix=1 busy=0",
                     enable, wraddress, pixel, clear_busy);
        end
        step();
        n_checks++;
        if (enable !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_no_requeue: en=%b busy=%b done=%b, required 0 0 0", enable, clear_busy, clear_done);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit seen_done;
        clear_start = 1'b1; clear_value = 1'b1;
        step();
        clear_start = 1'b0;
        for (int k = 1; k < 2000; k++) step();
        n_checks++;
        if (wraddress !== 12'd1999 || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_progress: addr=%0d busy=%b, required addr=1999 busy=1", wraddress, clear_busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (enable !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_reset: en=%b busy=%b done=%b, required 0 0 0", enable, clear_busy, clear_done);
        end
        req0_valid = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || clear_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_serve: r0=%b done=%b, required r0=1 done=0", req0_ready, clear_done);
        end
        req0_valid = 1'b0;
        step();
        n_checks++;
        if (clear_done !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_no_done: done=%b en=%b, required 0 0", clear_done, enable);
        end
        clear_start = 1'b1; clear_value = 1'b1;
        step();
        clear_start = 1'b0;
        n_checks++;
        if (enable !== 1'b1 || wraddress !== 12'h000 || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_addr0: en=%b addr=%h busy=%b, required en=1 addr=000 busy=1", enable, wraddress, clear_busy);
        end
        step();
        n_checks++;
        if (wraddress !== 12'h001) begin
            n_fail++;
            $display("FAIL restart_addr1: addr=%h, required 001", wraddress);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 5000 && !seen_done; c++) begin
            step();
            seen_done = clear_done;
        end
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL restart_done_timeout: clear_done=0 after 5000 cycles, required a done pulse");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_clear();
        test_collision();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
